// File: rtl/ro_slot_rx.sv
// Receive-side slot decoder for a shared Gray-scheduled readout line.
// Mirrors the transmitter counter, samples the line on the falling edge and emits tagged bits.
module ro_slot_rx #(
  parameter int NCH = 17,
  parameter int CHW = 5
) (
  input  logic           clk_ext,
  input  logic           rstb,
  input  logic           en,
  input  logic           restart,
  input  logic           mux_in,
  output logic           out_valid,
  output logic [CHW-1:0] out_chan,
  output logic           out_bit,
  output logic           frame_done,
  output logic [NCH-1:0] chan_bits,
  output logic [NCH-1:0] slot_cnt
);

  logic [NCH-1:0] cnt;
  logic [CHW-1:0] slot_idx;
  logic [CHW-1:0] next_idx;
  logic           slot_live;
  logic           slot_wrap;

  logic           cap_bit;
  logic [CHW-1:0] cap_chan;
  logic           cap_live;
  logic           cap_wrap;

  // Trailing-ones count of cnt; all-ones (and MSB-only-zero) both land on NCH-1.
  always_comb begin
    next_idx = CHW'(NCH - 1);
    for (int i = NCH - 2; i >= 0; i--) begin
      if (!cnt[i]) next_idx = CHW'(i);
    end
  end

  always_ff @(posedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      cnt        <= '0;
      slot_idx   <= '0;
      slot_live  <= 1'b0;
      slot_wrap  <= 1'b0;
      out_valid  <= 1'b0;
      out_chan   <= '0;
      out_bit    <= 1'b0;
      frame_done <= 1'b0;
      chan_bits  <= '0;
    end else begin
      if (restart) begin
        cnt       <= '0;
        slot_idx  <= '0;
        slot_live <= 1'b0;
        slot_wrap <= 1'b0;
      end else if (en) begin
        slot_idx  <= next_idx;
        slot_live <= 1'b1;
        slot_wrap <= &cnt;
        cnt       <= cnt + NCH'(1);
      end else begin
        slot_live <= 1'b0;
      end

      // A restart flushes the slot sampled just before it.
      out_valid  <= cap_live & ~restart;
      out_chan   <= cap_chan;
      out_bit    <= cap_bit;
      frame_done <= cap_live & ~restart & cap_wrap & (cap_chan == CHW'(NCH - 1));
      if (cap_live && !restart) chan_bits[cap_chan] <= cap_bit;
    end
  end

  // The transmitter only drives while clk_ext is high, so sample on the falling edge.
  always_ff @(negedge clk_ext or negedge rstb) begin
    if (!rstb) begin
      cap_bit  <= 1'b0;
      cap_chan <= '0;
      cap_live <= 1'b0;
      cap_wrap <= 1'b0;
    end else begin
      cap_bit  <= slot_live & (mux_in === 1'b1);
      cap_chan <= slot_idx;
      cap_live <= slot_live;
      cap_wrap <= slot_wrap;
    end
  end

  assign slot_cnt = cnt;

endmodule

// File: tb/tb_ro_slot_rx.sv
// Self-checking bench for ro_slot_rx: table vectors, hand sequences and random
// traffic against a Gray-code level reference model (NCH=4).
module tb_ro_slot_rx;
  localparam int N = 4;
  localparam int W = 2;

  logic         clk_ext = 1'b0;
  logic         rstb = 1'b0;
  logic         en = 1'b0;
  logic         restart = 1'b0;
  logic         mux_in = 1'b0;
  logic         out_valid;
  logic [W-1:0] out_chan;
  logic         out_bit;
  logic         frame_done;
  logic [N-1:0] chan_bits;
  logic [N-1:0] slot_cnt;

  ro_slot_rx #(.NCH(N), .CHW(W)) dut (
    .clk_ext(clk_ext), .rstb(rstb), .en(en), .restart(restart), .mux_in(mux_in),
    .out_valid(out_valid), .out_chan(out_chan), .out_bit(out_bit),
    .frame_done(frame_done), .chan_bits(chan_bits), .slot_cnt(slot_cnt)
  );

  always #5 clk_ext = ~clk_ext;

  int errors = 0;
  int checks = 0;

  // Reference model: slot counter, one pending slot, per-channel latest bits.
  int           m_cnt;
  bit           p_live, p_bit, p_wrap;
  int           p_chan;
  logic [N-1:0] m_bits;
  int           n_fd;
  int           n_ch[N];

  typedef struct {
    bit en;
    bit rs;
    bit ev;
    int ec;
  } vec_t;
  vec_t vecs[9];

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Channel = Gray bit that toggles between count c and c+1.
  function automatic int gray_chan(int c);
    int n, d;
    n = (c + 1) % (1 << N);
    d = (c ^ (c >> 1)) ^ (n ^ (n >> 1));
    return $clog2(d);
  endfunction

  task automatic model_reset();
    m_cnt  = 0;
    p_live = 0;
    p_bit  = 0;
    p_wrap = 0;
    p_chan = 0;
    m_bits = '0;
  endtask

  task automatic step(bit en_v, bit rs_v, int mode);
    bit ev, eb, ef;
    int ec;
    en = en_v;
    restart = rs_v;
    @(posedge clk_ext);
    #1;
    ev = p_live && !rs_v;
    ec = p_chan;
    eb = p_bit;
    ef = ev && p_wrap;
    if (ev) m_bits[ec] = eb;
    if (rs_v) begin
      m_cnt  = 0;
      p_live = 0;
    end else if (en_v) begin
      p_live = 1;
      p_chan = gray_chan(m_cnt);
      p_wrap = (m_cnt == (1 << N) - 1);
      m_cnt  = (m_cnt + 1) % (1 << N);
      if (mode == 0) p_bit = 1;
      else if (mode == 1) p_bit = (p_chan == 2);
      else p_bit = 1'($urandom % 2);
    end else begin
      p_live = 0;
    end
    mux_in = p_live ? p_bit : 1'($urandom % 2);
    chk("out_valid", out_valid, ev);
    if (ev) begin
      chk("out_chan", out_chan, ec);
      chk("out_bit", out_bit, eb);
    end
    chk("frame_done", frame_done, ef);
    chk("slot_cnt", slot_cnt, m_cnt);
    chk("chan_bits", chan_bits, m_bits);
    if (out_valid) begin
      n_ch[out_chan]++;
      if (frame_done) n_fd++;
    end
  endtask

  task automatic do_reset();
    en = 0;
    restart = 0;
    rstb = 0;
    #2;
    @(negedge clk_ext);
    rstb = 1;
    model_reset();
  endtask

  initial begin
    model_reset();
    vecs[0] = '{1, 0, 0, 0};
    vecs[1] = '{1, 0, 1, 0};
    vecs[2] = '{1, 0, 1, 1};
    vecs[3] = '{1, 0, 1, 0};
    vecs[4] = '{1, 0, 1, 2};
    vecs[5] = '{1, 0, 1, 0};
    vecs[6] = '{1, 0, 1, 1};
    vecs[7] = '{1, 0, 1, 0};
    vecs[8] = '{1, 0, 1, 3};

    #12;
    chk("rst_valid", out_valid, 0);
    chk("rst_chan", out_chan, 0);
    chk("rst_bit", out_bit, 0);
    chk("rst_frame", frame_done, 0);
    chk("rst_bits", chan_bits, 0);
    chk("rst_cnt", slot_cnt, 0);
    @(negedge clk_ext);
    rstb = 1;

    // First eight slots with the line held high.
    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].rs, 0);
      chk("tbl_valid", out_valid, vecs[i].ev);
      if (vecs[i].ev) begin
        chk("tbl_chan", out_chan, vecs[i].ec);
        chk("tbl_bit", out_bit, 1);
      end
    end
    chk("tbl_chan_bits", chan_bits, 'hF);
    chk("tbl_cnt", slot_cnt, 9);

    // Restart at cnt=9 with a slot in flight.
    step(1, 1, 0);
    chk("rs_valid", out_valid, 0);
    chk("rs_cnt", slot_cnt, 0);
    chk("rs_bits", chan_bits, 'hF);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("rs_next_valid", out_valid, 1);
    chk("rs_next_chan", out_chan, 0);

    // Drop en for 5 cycles at cnt=6.
    for (int g = 0; g < 20 && m_cnt != 6; g++) step(1, 0, 0);
    chk("pause_cnt_reached", slot_cnt, 6);
    step(0, 0, 0);
    chk("pause_inflight", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      step(i == 4, 0, 0);
      chk("pause_idle_valid", out_valid, 0);
      if (i < 4) chk("pause_hold_cnt", slot_cnt, 6);
    end
    step(1, 0, 0);
    chk("resume_chan0", out_chan, 0);
    step(1, 0, 0);
    chk("resume_chan3", out_chan, 3);

    // Line high only in channel-2 slots.
    do_reset();
    for (int i = 0; i < 16; i++) step(1, 0, 1);
    step(0, 0, 1);
    chk("ch2_bits", chan_bits, 'b0100);

    // Two full frames.
    do_reset();
    n_fd = 0;
    foreach (n_ch[i]) n_ch[i] = 0;
    for (int i = 0; i < 33; i++) step(1, 0, 0);
    chk("frame_count", n_fd, 2);
    chk("ch3_count", n_ch[3], 4);
    chk("ch0_count", n_ch[0], 16);

    // Reset between falling and rising edge of a live slot.
    step(1, 0, 0);
    @(negedge clk_ext);
    #1;
    rstb = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_chan", out_chan, 0);
    chk("mid_rst_bit", out_bit, 0);
    chk("mid_rst_frame", frame_done, 0);
    chk("mid_rst_bits", chan_bits, 0);
    chk("mid_rst_cnt", slot_cnt, 0);
    @(posedge clk_ext);
    #1;
    chk("mid_rst_no_strobe", out_valid, 0);
    do_reset();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, ($urandom % 32) == 0, 2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
